// File: rtl/im_fetch_pkg.sv
// Shared helpers for the item-memory fetch stage.
package im_fetch_pkg;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/im_fetch_stage_fifo.sv
// Synchronous result FIFO with a registered head word.
module im_fetch_fifo
    import im_fetch_pkg::*;
#(
    parameter int unsigned Width = 512,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = cnt_width(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] head_q, head_d;
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == DepthC);
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = head_q;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (clr_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = inc(wr_q);
            if (do_pop)  rd_d = inc(rd_q);
            if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
            if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
            // Head is the oldest live word, refreshed whenever it changes.
            if (do_pop) begin
                if (cnt_q == CntW'(1)) begin
                    if (do_push) head_d = wdata_i;
                end else begin
                    head_d = mem_q[inc(rd_q)];
                end
            end else if (do_push && empty_o) begin
                head_d = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_q] <= wdata_i;
    end

    a_no_overflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i && !clr_i)
    );

endmodule

// File: rtl/im_fetch_stage.sv
// Item-memory fetch stage: credit-gated reads into an in-order result FIFO.
module im_fetch_stage
    import im_fetch_pkg::*;
#(
    parameter int unsigned NumTotIm    = 1024,
    parameter int unsigned HVDimension = 512,
    parameter int unsigned ReadLatency = 1,
    parameter int unsigned FifoDepth   = 4,
    parameter int unsigned ImAddrWidth = $clog2(NumTotIm)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic [ImAddrWidth-1:0] addr_i,
    input  logic                   addr_valid_i,
    output logic                   addr_ready_o,
    output logic                   mem_req_o,
    output logic [ImAddrWidth-1:0] mem_addr_o,
    input  logic [HVDimension-1:0] mem_rdata_i,
    output logic [HVDimension-1:0] hv_o,
    output logic                   hv_valid_o,
    input  logic                   hv_ready_i,
    output logic                   busy_o
);
    localparam int unsigned UsedW = cnt_width(FifoDepth);
    localparam logic [UsedW-1:0] DepthU = UsedW'(FifoDepth);

    logic                   flush;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [UsedW-1:0]       used_q, used_d;
    logic [ReadLatency-1:0] vld_q, vld_d;

    assign flush = ~en_i | clr_i;

    // Credits cover in-flight reads too, so a landing read always has a slot.
    assign addr_ready_o = rst_ni & ~flush & (used_q < DepthU);
    assign accept       = addr_ready_o & addr_valid_i;
    assign mem_req_o    = accept;
    assign mem_addr_o   = addr_i;

    assign push       = vld_q[ReadLatency-1] & ~flush;
    assign hv_valid_o = ~flush & ~fifo_empty;
    assign pop        = hv_valid_o & hv_ready_i;
    assign busy_o     = (used_q != '0);

    always_comb begin
        vld_d  = ReadLatency'({vld_q, accept});
        used_d = used_q + UsedW'(accept) - UsedW'(pop);
        if (flush) begin
            vld_d  = '0;
            used_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            used_q <= '0;
        end else begin
            vld_q  <= vld_d;
            used_q <= used_d;
        end
    end

    im_fetch_fifo #(
        .Width (HVDimension),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (flush),
        .push_i  (push),
        .wdata_i (mem_rdata_i),
        .pop_i   (pop),
        .rdata_o (hv_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_used_bound : assert property (
        @(posedge clk_i) disable iff (!rst_ni) used_q <= DepthU
    );

    a_push_room : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full && !pop)
    );

endmodule

// File: tb/tb_im_fetch_stage.sv
// Directed bench for im_fetch_stage at ReadLatency 1 and 3.
module tb_im_fetch_stage;
    localparam int AW = 10;
    localparam int DW = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni;
    logic          en_a, clr_a, av_a, ar_a, req_a, hvv_a, hvr_a, busy_a;
    logic [AW-1:0] addr_a, maddr_a;
    logic [DW-1:0] rd_a, hv_a;
    logic          en_b, clr_b, av_b, ar_b, req_b, hvv_b, hvr_b, busy_b;
    logic [AW-1:0] addr_b, maddr_b;
    logic [DW-1:0] rd_b, hv_b;

    int checks = 0;
    int failures = 0;
    logic [AW-1:0] q_a[$];
    logic [AW-1:0] q_b[$];
    int pops_a = 0;
    int pops_b = 0;
    logic s_rdy_a, s_val_a, s_busy_a, s_rdy_b, s_val_b, s_busy_b;
    logic [DW-1:0] s_hv_a;

    im_fetch_stage dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_a), .clr_i(clr_a),
        .addr_i(addr_a), .addr_valid_i(av_a), .addr_ready_o(ar_a),
        .mem_req_o(req_a), .mem_addr_o(maddr_a), .mem_rdata_i(rd_a),
        .hv_o(hv_a), .hv_valid_o(hvv_a), .hv_ready_i(hvr_a),
        .busy_o(busy_a)
    );

    im_fetch_stage #(.ReadLatency(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_b), .clr_i(clr_b),
        .addr_i(addr_b), .addr_valid_i(av_b), .addr_ready_o(ar_b),
        .mem_req_o(req_b), .mem_addr_o(maddr_b), .mem_rdata_i(rd_b),
        .hv_o(hv_b), .hv_valid_o(hvv_b), .hv_ready_i(hvr_b),
        .busy_o(busy_b)
    );

    function automatic logic [DW-1:0] hvf(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++)
            r[i*32 +: 32] = {6'd0, a, 16'(i)} ^ 32'h5A5A_1234;
        return r;
    endfunction

    // Item memories: latency 1 for A, 3 for B; junk when no read returns.
    logic          p_req[3];
    logic [AW-1:0] p_adr[3];
    always @(posedge clk) begin
        rd_a <= req_a ? hvf(maddr_a) : {16{32'hDEAD_BEEF}};
        p_req[0] <= req_b;
        p_adr[0] <= maddr_b;
        p_req[1] <= p_req[0];
        p_adr[1] <= p_adr[0];
        p_req[2] <= p_req[1];
        p_adr[2] <= p_adr[1];
    end
    assign rd_b = p_req[2] ? hvf(p_adr[2]) : {16{32'hBAD0_F00D}};

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, update scoreboards, return at posedge+1.
    task automatic step();
        @(negedge clk);
        s_rdy_a = ar_a; s_val_a = hvv_a; s_busy_a = busy_a; s_hv_a = hv_a;
        s_rdy_b = ar_b; s_val_b = hvv_b; s_busy_b = busy_b;
        chk("reqA", req_a, av_a & ar_a);
        chk("reqB", req_b, av_b & ar_b);
        if (req_a) chk("maddrA", maddr_a, addr_a);
        if (hvv_a && hvr_a) begin
            pops_a++;
            chk("popA_q", q_a.size() != 0, 1);
            if (q_a.size() != 0) chk("popA", hv_a, hvf(q_a.pop_front()));
        end
        if (hvv_b && hvr_b) begin
            pops_b++;
            chk("popB_q", q_b.size() != 0, 1);
            if (q_b.size() != 0) chk("popB", hv_b, hvf(q_b.pop_front()));
        end
        if (av_a && ar_a) q_a.push_back(addr_a);
        if (av_b && ar_b) q_b.push_back(addr_b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int i;
        int p0;
        rst_ni = 1'b0;
        en_a = 1; clr_a = 0; av_a = 1; addr_a = '0; hvr_a = 1;
        en_b = 1; clr_b = 0; av_b = 1; addr_b = '0; hvr_b = 1;
        #2;
        chk("rst_rdy", ar_a, 0);
        chk("rst_req", req_a, 0);
        chk("rst_val", hvv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_hv", hv_a, '0);
        chk("rst_rdyB", ar_b, 0);
        av_a = 0; av_b = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back 0..7, consumer always ready.
        for (int k = 0; k < 12; k++) begin
            av_a = (k < 8);
            addr_a = AW'(k);
            step();
            if (k < 8) chk("t1rdy", s_rdy_a, 1);
            chk("t1val", s_val_a, (k >= 2 && k < 10));
            if (k >= 2 && k < 10) chk("t1hv", s_hv_a, hvf(AW'(k - 2)));
        end

        // Stalled consumer, 10 addresses.
        hvr_a = 0;
        i = 0;
        for (int k = 0; k < 8; k++) begin
            av_a = (i < 10);
            addr_a = AW'(20 + i);
            step();
            if (av_a && s_rdy_a) i++;
        end
        chk("t2acc", i, 4);
        chk("t2rdy", s_rdy_a, 0);
        chk("t2busy", s_busy_a, 1);
        hvr_a = 1;
        p0 = pops_a;
        for (int k = 0; k < 60 && pops_a < p0 + 10; k++) begin
            av_a = (i < 10);
            addr_a = AW'(20 + i);
            step();
            if (av_a && s_rdy_a) i++;
        end
        av_a = 0;
        chk("t2pops", pops_a - p0, 10);

        // Latency 3, depth 4: one bubble every fifth cycle.
        i = 0;
        p0 = pops_b;
        for (int k = 0; k < 100 && pops_b < p0 + 20; k++) begin
            av_b = (i < 20);
            addr_b = AW'(100 + i);
            step();
            if (k < 20) chk("t3rdy", s_rdy_b, (k % 5) != 4);
            if (av_b && s_rdy_b) i++;
        end
        av_b = 0;
        chk("t3pops", pops_b - p0, 20);

        // Flush with two reads in flight and two results buffered.
        hvr_b = 0;
        for (int k = 0; k < 4; k++) begin
            av_b = 1;
            addr_b = AW'(200 + k);
            step();
        end
        av_b = 0;
        step();
        chk("t4val_pre", s_val_b, 1);
        chk("t4busy_pre", s_busy_b, 1);
        clr_b = 1;
        step();
        chk("t4rdy_clr", s_rdy_b, 0);
        chk("t4val_clr", s_val_b, 0);
        clr_b = 0;
        q_b.delete();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4val_post", s_val_b, 0);
            chk("t4busy_post", s_busy_b, 0);
        end
        hvr_b = 1;
        av_b = 1;
        addr_b = AW'(5);
        step();
        av_b = 0;
        p0 = pops_b;
        for (int k = 0; k < 10; k++) step();
        chk("t4one", pops_b - p0, 1);
        en_b = 0;
        av_b = 1;
        step();
        chk("t4en_rdy", s_rdy_b, 0);
        chk("t4en_val", s_val_b, 0);
        av_b = 0;
        en_b = 1;

        // Sit at FifoDepth-1 with random consumer.
        hvr_a = 0;
        i = 0;
        for (int k = 0; k < 3; k++) begin
            av_a = 1;
            addr_a = AW'(300 + i);
            step();
            i++;
        end
        av_a = 0;
        step();
        step();
        for (int k = 0; k < 50; k++) begin
            av_a = 1;
            addr_a = AW'(300 + i);
            hvr_a = 1'($urandom_range(0, 1));
            step();
            if (s_rdy_a) i++;
            chk("t5used", dut_a.used_q <= 3'd4, 1);
        end
        av_a = 0;
        hvr_a = 1;
        for (int k = 0; k < 20 && q_a.size() != 0; k++) step();
        chk("t5drain", q_a.size(), 0);

        // Async reset with results buffered.
        hvr_a = 0;
        for (int k = 0; k < 2; k++) begin
            av_a = 1;
            addr_a = AW'(400 + k);
            step();
        end
        av_a = 0;
        step();
        step();
        chk("t6half", s_val_a, 1);
        av_a = 1;
        addr_a = AW'(77);
        rst_ni = 0;
        #1;
        chk("t6rdy", ar_a, 0);
        chk("t6req", req_a, 0);
        chk("t6val", hvv_a, 0);
        chk("t6busy", busy_a, 0);
        chk("t6hv", hv_a, '0);
        av_a = 0;
        @(negedge clk);
        rst_ni = 1;
        q_a.delete();
        q_b.delete();
        @(posedge clk);
        #1;
        av_a = 1;
        addr_a = AW'(42);
        hvr_a = 1;
        step();
        chk("t6acc", s_rdy_a, 1);
        av_a = 0;
        p0 = pops_a;
        for (int k = 0; k < 10 && pops_a == p0; k++) step();
        chk("t6pop", pops_a - p0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
